// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between IF and LS, LS first, with a starvation guard for IF
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  input  logic                ls_req_valid,
  input  logic                ls_req_we,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic                ls_req_ready,
  output logic                ls_rsp_valid,
  output logic [DATA_W-1:0]   ls_rsp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;
  state_t        state;
  owner_t        owner;
  logic [3:0]    lat_cnt;
  logic [CW-1:0] starve_cnt;
  logic          grant_ls, grant_if;
  always_comb begin
    grant_ls = state == IDLE && ls_req_valid && !(if_req_valid && starve_cnt == CW'(STARVE_MAX));
    grant_if = state == IDLE && if_req_valid && !grant_ls;
  end
  assign ls_req_ready = grant_ls;
  assign if_req_ready = grant_if;
  assign busy         = state != IDLE;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= OWN_IF;
      lat_cnt      <= '0;
      starve_cnt   <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      ls_rsp_data  <= '0;
    end else begin
      mem_en       <= 1'b0;
      if_rsp_valid <= 1'b0;
      ls_rsp_valid <= 1'b0;
      // counts LS wins only while IF is actually waiting
      starve_cnt   <= (!if_req_valid || grant_if) ? '0 :
                      (grant_ls && starve_cnt != CW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
      case (state)
        IDLE: if (grant_ls || grant_if) begin
          state     <= ISSUE;
          mem_en    <= 1'b1;
          owner     <= grant_ls ? OWN_LS : OWN_IF;
          mem_addr  <= grant_ls ? ls_req_addr : if_req_addr;
          mem_we    <= grant_ls && ls_req_we;
          mem_wstrb <= (grant_ls && ls_req_we) ? ls_req_wstrb : '0;
          if (grant_ls && ls_req_we) mem_wdata <= ls_req_wdata;
        end
        ISSUE: begin
          state   <= WAIT;
          lat_cnt <= 4'(RD_LAT - 1);
        end
        WAIT: if (lat_cnt == '0) begin
          state <= IDLE;
          if (owner == OWN_LS) begin
            ls_rsp_valid <= 1'b1;
            ls_rsp_data  <= mem_we ? '0 : mem_rdata;
          end else begin
            if_rsp_valid <= 1'b1;
            if_rsp_data  <= mem_rdata;
          end
        end else lat_cnt <= lat_cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench, instance 0 at RD_LAT=1 and instance 1 at RD_LAT=3
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  int pass = 0;
  int total = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_v[2], if_rdy[2], if_rv[2], ls_v[2], ls_we[2], ls_rdy[2], ls_rv[2];
  logic        mem_en[2], mem_we[2], busy[2];
  logic [31:0] if_addr[2], if_rd[2], ls_addr[2], ls_wd[2], ls_rd[2], mem_addr[2], mem_wdata[2];
  logic [3:0]  ls_ws[2], mem_wstrb[2];
  logic [31:0] mem [logic [31:0]];

  typedef struct { bit ls; logic [31:0] data; int due; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; int due; } iss_t;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a ^ 32'h1234_5678;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = g == 0 ? 1 : 3;
    int          mcnt = 0;
    logic [31:0] maddr = '0;
    logic [31:0] rdata = 32'hBAD0_BAD0;
    rsp_t        q[$];
    iss_t        iss;
    bit          iss_pend = 0;

    mem_port_arbiter #(.RD_LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req_valid(if_v[g]), .if_req_addr(if_addr[g]), .if_req_ready(if_rdy[g]),
      .if_rsp_valid(if_rv[g]), .if_rsp_data(if_rd[g]),
      .ls_req_valid(ls_v[g]), .ls_req_we(ls_we[g]), .ls_req_addr(ls_addr[g]),
      .ls_req_wdata(ls_wd[g]), .ls_req_wstrb(ls_ws[g]), .ls_req_ready(ls_rdy[g]),
      .ls_rsp_valid(ls_rv[g]), .ls_rsp_data(ls_rd[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_wstrb(mem_wstrb[g]), .mem_rdata(rdata),
      .busy(busy[g])
    );

    // RAM model: data is valid only in the cycle LAT after the strobe
    always @(posedge clk) begin
      automatic int n = mem_en[g] ? LAT : (mcnt > 0 ? mcnt - 1 : 0);
      automatic logic [31:0] a = mem_en[g] ? mem_addr[g] : maddr;
      mcnt  <= n;
      maddr <= a;
      rdata <= n == 1 ? rd(a) : 32'hBAD0_BAD0;
    end

    always @(negedge clk) begin
      if (!reset_n) begin
        q.delete();
        iss_pend = 0;
      end else begin
        if (if_rv[g] || ls_rv[g]) begin
          total++;
          if (q.size() == 0)
            $display("FAIL inst%0d rsp_unexpected cyc=%0d if_rsp_valid=%b ls_rsp_valid=%b, want no response",
                     g, cyc, if_rv[g], ls_rv[g]);
          else begin
            automatic rsp_t e = q.pop_front();
            automatic logic [31:0] d = e.ls ? ls_rd[g] : if_rd[g];
            if (ls_rv[g] !== e.ls || if_rv[g] !== !e.ls || d !== e.data || cyc != e.due)
              $display("FAIL inst%0d rsp cyc=%0d if_v=%b ls_v=%b data=%h, want cyc=%0d ls=%b data=%h",
                       g, cyc, if_rv[g], ls_rv[g], d, e.due, e.ls, e.data);
            else pass++;
          end
        end else if (q.size() != 0 && cyc > q[0].due) begin
          total++;
          $display("FAIL inst%0d rsp_missing cyc=%0d got none, want response due at cyc=%0d", g, cyc, q[0].due);
          q.delete(0);
        end
        if (iss_pend && cyc == iss.due) begin
          total++;
          iss_pend = 0;
          if (mem_en[g] !== 1'b1 || mem_we[g] !== iss.we || mem_addr[g] !== iss.addr ||
              mem_wstrb[g] !== iss.wstrb || (iss.we && mem_wdata[g] !== iss.wdata))
            $display("FAIL inst%0d issue cyc=%0d en=%b we=%b addr=%h wstrb=%h wdata=%h, want 1 %b %h %h %h",
                     g, cyc, mem_en[g], mem_we[g], mem_addr[g], mem_wstrb[g], mem_wdata[g],
                     iss.we, iss.addr, iss.wstrb, iss.wdata);
          else pass++;
        end else if (mem_en[g]) begin
          total++;
          $display("FAIL inst%0d strobe_unexpected cyc=%0d mem_en=1, want 0", g, cyc);
        end
        total++;
        if (if_rdy[g] && ls_rdy[g])
          $display("FAIL inst%0d ready_exclusive cyc=%0d if_ready=1 ls_ready=1, want at most one", g, cyc);
        else pass++;
        if (ls_v[g] && ls_rdy[g]) begin
          automatic logic [31:0] w = rd(ls_addr[g]);
          q.push_back('{1'b1, ls_we[g] ? 32'h0 : rd(ls_addr[g]), cyc + 2 + LAT});
          iss = '{ls_we[g], ls_addr[g], ls_wd[g], ls_we[g] ? ls_ws[g] : 4'h0, cyc + 1};
          iss_pend = 1;
          if (ls_we[g]) begin
            for (int b = 0; b < 4; b++) if (ls_ws[g][b]) w[8*b +: 8] = ls_wd[g][8*b +: 8];
            mem[ls_addr[g]] = w;
          end
        end else if (if_v[g] && if_rdy[g]) begin
          q.push_back('{1'b0, rd(if_addr[g]), cyc + 2 + LAT});
          iss = '{1'b0, if_addr[g], 32'h0, 4'h0, cyc + 1};
          iss_pend = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) step();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({mem_en[g], mem_we[g], mem_addr[g], mem_wdata[g], mem_wstrb[g], if_rv[g], ls_rv[g],
           if_rd[g], ls_rd[g], busy[g]} !== '0)
        $display("FAIL inst%0d reset_init en=%b we=%b addr=%h wd=%h ws=%h rv=%b%b rd=%h/%h busy=%b, want all 0",
                 g, mem_en[g], mem_we[g], mem_addr[g], mem_wdata[g], mem_wstrb[g], if_rv[g], ls_rv[g],
                 if_rd[g], ls_rd[g], busy[g]);
      else pass++;
    end
    step();
    reset_n = 1;
    if_v[0] = 1; if_addr[0] = 32'h40;
    ls_v[0] = 1; ls_we[0] = 0; ls_addr[0] = 32'h200;
    step();
    step();
    reset_n = 0;
    @(negedge clk);
    total++;
    if (busy[0] !== 1'b1) $display("FAIL reset_midwait_busy busy=%b, want 1", busy[0]);
    else pass++;
    step();
    @(negedge clk);
    total++;
    if ({mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0], mem_wstrb[0], if_rv[0], ls_rv[0],
         if_rd[0], ls_rd[0], busy[0]} !== '0)
      $display("FAIL reset_drop en=%b addr=%h rv=%b%b rd=%h/%h busy=%b, want all 0",
               mem_en[0], mem_addr[0], if_rv[0], ls_rv[0], if_rd[0], ls_rd[0], busy[0]);
    else pass++;
    step();
    reset_n = 1;
    @(negedge clk);
    total++;
    if (ls_rdy[0] !== 1'b1 || if_rdy[0] !== 1'b0)
      $display("FAIL reset_first_grant ls_ready=%b if_ready=%b, want 1 0", ls_rdy[0], if_rdy[0]);
    else pass++;
    step();
    if_v[0] = 0; ls_v[0] = 0;
    repeat (6) step();
  endtask

  task automatic test_if_read();
    if_v[0] = 1; if_addr[0] = 32'h0080_0000;
    @(negedge clk);
    total++;
    if (if_rdy[0] !== 1'b1 || ls_rdy[0] !== 1'b0)
      $display("FAIL if_read_ready if_ready=%b ls_ready=%b, want 1 0", if_rdy[0], ls_rdy[0]);
    else pass++;
    step();
    if_v[0] = 0;
    @(negedge clk);
    total++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b0 || mem_wstrb[0] !== 4'h0 || mem_addr[0] !== 32'h0080_0000)
      $display("FAIL if_read_issue en=%b we=%b wstrb=%h addr=%h, want 1 0 0 00800000",
               mem_en[0], mem_we[0], mem_wstrb[0], mem_addr[0]);
    else pass++;
    step();
    step();
    @(negedge clk);
    total++;
    if (if_rv[0] !== 1'b1 || if_rd[0] !== 32'h13 || ls_rv[0] !== 1'b0)
      $display("FAIL if_read_rsp if_rsp_valid=%b data=%h ls_rsp_valid=%b, want 1 00000013 0",
               if_rv[0], if_rd[0], ls_rv[0]);
    else pass++;
    repeat (2) step();
  endtask

  task automatic test_ls_write();
    ls_v[0] = 1; ls_we[0] = 1; ls_addr[0] = 32'h100; ls_wd[0] = 32'hDEAD_BEEF; ls_ws[0] = 4'b0011;
    @(negedge clk);
    total++;
    if (ls_rdy[0] !== 1'b1) $display("FAIL ls_write_ready ls_ready=%b, want 1", ls_rdy[0]);
    else pass++;
    step();
    ls_v[0] = 0; ls_we[0] = 0;
    @(negedge clk);
    total++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 || mem_wstrb[0] !== 4'b0011 ||
        mem_wdata[0] !== 32'hDEAD_BEEF || mem_addr[0] !== 32'h100)
      $display("FAIL ls_write_issue en=%b we=%b wstrb=%h wdata=%h addr=%h, want 1 1 3 deadbeef 00000100",
               mem_en[0], mem_we[0], mem_wstrb[0], mem_wdata[0], mem_addr[0]);
    else pass++;
    step();
    step();
    @(negedge clk);
    total++;
    if (ls_rv[0] !== 1'b1 || ls_rd[0] !== 32'h0 || if_rv[0] !== 1'b0)
      $display("FAIL ls_write_ack ls_rsp_valid=%b data=%h if_rsp_valid=%b, want 1 0 0",
               ls_rv[0], ls_rd[0], if_rv[0]);
    else pass++;
    repeat (2) step();
  endtask

  task automatic test_contention();
    if_v[0] = 1; if_addr[0] = 32'h300;
    ls_v[0] = 1; ls_we[0] = 0; ls_addr[0] = 32'h400;
    @(negedge clk);
    total++;
    if (ls_rdy[0] !== 1'b1 || if_rdy[0] !== 1'b0)
      $display("FAIL contention_grant ls_ready=%b if_ready=%b, want 1 0", ls_rdy[0], if_rdy[0]);
    else pass++;
    step();
    ls_v[0] = 0;
    @(negedge clk);
    total++;
    if (if_rdy[0] !== 1'b0) $display("FAIL contention_busy_ready if_ready=%b, want 0", if_rdy[0]);
    else pass++;
    step();
    step();
    @(negedge clk);
    total++;
    if (if_rdy[0] !== 1'b1 || ls_rv[0] !== 1'b1)
      $display("FAIL contention_if_accept if_ready=%b ls_rsp_valid=%b, want 1 1", if_rdy[0], ls_rv[0]);
    else pass++;
    step();
    if_v[0] = 0;
    repeat (4) step();
  endtask

  task automatic test_starvation();
    string seq = "";
    int n = 0;
    int guard = 0;
    if_v[0] = 1; if_addr[0] = 32'h600;
    ls_v[0] = 1; ls_we[0] = 0; ls_addr[0] = 32'h500;
    while (n < 10 && guard < 100) begin
      @(negedge clk);
      if (ls_v[0] && ls_rdy[0]) begin seq = {seq, "L"}; n++; end
      else if (if_v[0] && if_rdy[0]) begin seq = {seq, "I"}; n++; end
      guard++;
      step();
    end
    total++;
    if (seq != "LLLLILLLLI") $display("FAIL starvation_order got %s, want LLLLILLLLI", seq);
    else pass++;
    if_v[0] = 0; ls_v[0] = 0;
    repeat (5) step();
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    ls_v[1] = 1; ls_we[1] = 0; ls_addr[1] = 32'h10;
    for (int c = 0; c <= 10; c++) begin
      if (c == 1) ls_addr[1] = 32'h14;
      if (c == 6) ls_v[1] = 0;
      @(negedge clk);
      exp_v = c == 5 || c == 10;
      total++;
      if (busy[1] !== !(c == 0 || c == 5 || c == 10))
        $display("FAIL b2b_busy c=%0d busy=%b, want %b", c, busy[1], !(c == 0 || c == 5 || c == 10));
      else pass++;
      total++;
      if (ls_rv[1] !== exp_v || (exp_v && ls_rd[1] !== (c == 5 ? 32'hA : 32'hB)))
        $display("FAIL b2b_rsp c=%0d ls_rsp_valid=%b data=%h, want %b %h",
                 c, ls_rv[1], ls_rd[1], exp_v, c == 5 ? 32'hA : 32'hB);
      else pass++;
      step();
    end
    repeat (2) step();
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      if_v[g] = 0; if_addr[g] = '0; ls_v[g] = 0; ls_we[g] = 0;
      ls_addr[g] = '0; ls_wd[g] = '0; ls_ws[g] = '0;
    end
    mem[32'h0080_0000] = 32'h13;
    mem[32'h10] = 32'hA;
    mem[32'h14] = 32'hB;
    test_reset();
    test_if_read();
    test_ls_write();
    test_contention();
    test_starvation();
    test_back_to_back();
    total++;
    if (inst[0].q.size() != 0 || inst[1].q.size() != 0)
      $display("FAIL drain pending=%0d/%0d, want 0/0", inst[0].q.size(), inst[1].q.size());
    else pass++;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
